myproject_mac_pipe_ce: RTL and testbench
========================================

// Module: myproject_mac_pipe_ce
// PURPOSE
//   Pipelined signed multiply / multiply-accumulate unit with clock enable and valid tracking.
//   Parametrised successor of the combinational myproject_mul_* cores: registered, stallable, per-beat mode.
//   Sits in the HEPT kernel datapath between operand fetch and the reduction/activation stage.
// PARAMETERS
//   ID          1   instance tag, no functional effect
//   NUM_STAGE   3   register stages input->dout, >=1; latency in cycles
//   din0_WIDTH  13  signed operand 0 width
//   din1_WIDTH  13  signed operand 1 width
//   dout_WIDTH  26  signed result/accumulator width, >=2
//   SATURATE    0   1: clamp result to signed dout range; 0: two's-complement wrap
// PORTS
//   ap_clk     in   1           clock, rising edge
//   ap_rst_n   in   1           asynchronous reset, active low
//   ce         in   1           clock enable; 0 freezes every register
//   din_vld    in   1           operand beat valid
//   acc_en     in   1           beat mode: 0 multiply, 1 accumulate
//   acc_first  in   1           with acc_en: beat starts a new accumulation
//   din0       in   din0_WIDTH  signed operand 0
//   din1       in   din1_WIDTH  signed operand 1
//   dout_vld   out  1           dout/ovf valid this cycle
//   dout       out  dout_WIDTH  signed product or running sum
//   ovf        out  1           this result saturated (SATURATE=1) or wrapped (SATURATE=0)
// BEHAVIOUR
//   - Reset (ap_rst_n=0, async): all stage valids, dout_vld, dout, ovf, accumulator <= 0; mode regs <= 0.
//   - Beat accepted at a rising edge with ce=1 and din_vld=1; din_vld=0 with ce=1 inserts a bubble.
//   - Latency: beat accepted at edge e -> dout_vld=1 with its result after edge e+NUM_STAGE-1,
//     i.e. NUM_STAGE cycles after presentation; throughput 1 beat/cycle, results in input order.
//   - ce=0: no register changes (pipeline, acc, dout, dout_vld, ovf hold); inputs ignored.
//   - dout_vld=1 for exactly one enabled cycle per accepted beat; bubbles give dout_vld=0
//     on the corresponding output cycle (dout holds the last value).
//   - Product: full precision din0_WIDTH+din1_WIDTH signed, then resized to dout_WIDTH.
//   - Multiply beat (acc_en=0): dout = resize(product); accumulator untouched.
//   - Accumulate beat, acc_first=1: acc = resize(product); dout = acc.
//   - Accumulate beat, acc_first=0: acc = resize(acc + product); dout = acc (running sum per beat).
//   - Sum computed in dout_WIDTH+1 bits before resize. Resize: SATURATE=1 clamps to
//     [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; SATURATE=0 keeps low dout_WIDTH bits.
//   - ovf=1 iff resize altered the value; ovf is per-result, not sticky; updates with dout_vld.
//   - Accumulator changes only on accumulate beats reaching the last stage; bubbles and
//     multiply beats interleaved in an accumulation leave it intact.
//   - NUM_STAGE=1: single output register (mult+add combinational). NUM_STAGE>=2: stage 1
//     registers operands/mode, product pipelined through middle stages, add in final stage.
//   - Reset asserted mid-stream: in-flight beats discarded, no dout_vld until new beats traverse.
// TESTING (din0_WIDTH=din1_WIDTH=13, dout_WIDTH=26, NUM_STAGE=3 unless stated)
//   1 Multiply: -4096*-4096, acc_en=0 -> dout=16777216, ovf=0, dout_vld exactly 3 cycles later.
//   2 Stream 4 back-to-back products (1*1,2*3,-5*7,4095*-4096) -> 1,6,-35,-16773120 on 4 consecutive
//     cycles; bubble between beats 2 and 3 -> one dout_vld=0 gap at same position.
//   3 Accumulate 100*200(first), -50*10, 7*7 -> dout 20000, 19500, 19549; ce=0 for 5 cycles mid-stream
//     -> outputs delayed by 5 cycles, values unchanged, no extra/dropped dout_vld.
//   4 SATURATE=1: accumulate 4095*4095 x3 -> 16769025, 33538050, 33554431 with ovf=0,0,1.
//     SATURATE=0 same stimulus -> third dout=-16801789, ovf=1.
//   5 Reset: drop ap_rst_n for 1 ns mid-accumulation with 3 beats in flight -> dout=0, dout_vld=0,
//     ovf=0 immediately (asynchronous); new first beat 3*3 -> dout=9.
//   6 NUM_STAGE=1: 12*-12 -> dout=-144 in cycle following presentation; interleaved multiply beat
//     inside accumulation leaves running sum intact.

Source files
------------

// File: rtl/myproject_mac_pipe_ce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : myproject_mac_pipe_ce
// Purpose  : Pipelined signed multiply / multiply-accumulate unit with clock
//            enable, per-beat mode select and valid tracking. Result is the
//            full-precision product resized to dout_WIDTH, or a running sum
//            held in an internal accumulator, optionally saturating.
// Ports    : ap_clk    - clock, rising edge
//            ap_rst_n  - asynchronous reset, active low
//            ce        - clock enable, 0 freezes every register
//            din_vld   - operand beat valid
//            acc_en    - beat mode: 0 multiply, 1 accumulate
//            acc_first - with acc_en: beat starts a new accumulation
//            din0/din1 - signed operands
//            dout_vld  - dout/ovf valid this cycle
//            dout      - signed product or running sum
//            ovf       - this result was clamped or wrapped
// Revision : 1.0 - initial release
// ============================================================================
module myproject_mac_pipe_ce #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 13,
    parameter int dout_WIDTH = 26,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         din_vld,
    input  logic                         acc_en,
    input  logic                         acc_first,
    input  logic [din0_WIDTH-1:0]        din0,
    input  logic [din1_WIDTH-1:0]        din1,
    output logic                         dout_vld,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int c_pw = din0_WIDTH + din1_WIDTH;
    // One guard bit above the wider of product and accumulator.
    localparam int c_sw = ((c_pw > dout_WIDTH) ? c_pw : dout_WIDTH) + 1;
    localparam logic [dout_WIDTH-1:0] c_min = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] c_max = ~c_min;

    if (NUM_STAGE < 1 || dout_WIDTH < 2 || ID < 0) begin : g_param_check
        $error("myproject_mac_pipe_ce: illegal parameter set");
    end

    // Signals presented to the final (add/resize/output) stage.
    logic                    w_fin_vld;
    logic                    w_fin_acc;
    logic                    w_fin_first;
    logic signed [c_pw-1:0]  w_fin_prod;

    if (NUM_STAGE == 1) begin : g_one
        logic signed [c_pw-1:0] w_a;
        logic signed [c_pw-1:0] w_b;
        assign w_a         = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
        assign w_b         = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
        assign w_fin_prod  = w_a * w_b;
        assign w_fin_vld   = din_vld;
        assign w_fin_acc   = acc_en;
        assign w_fin_first = acc_first;
    end else begin : g_multi
        logic [din0_WIDTH-1:0]  r_s1_a;
        logic [din1_WIDTH-1:0]  r_s1_b;
        logic                   r_s1_vld;
        logic                   r_s1_acc;
        logic                   r_s1_first;
        logic signed [c_pw-1:0] w_a;
        logic signed [c_pw-1:0] w_b;
        logic signed [c_pw-1:0] w_prod;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_s1_a     <= '0;
                r_s1_b     <= '0;
                r_s1_vld   <= 1'b0;
                r_s1_acc   <= 1'b0;
                r_s1_first <= 1'b0;
            end else if (ce) begin
                r_s1_vld   <= din_vld;
                r_s1_acc   <= acc_en;
                r_s1_first <= acc_first;
                // Operands only load on real beats to avoid multiplier toggling.
                if (din_vld) begin
                    r_s1_a <= din0;
                    r_s1_b <= din1;
                end
            end
        end

        assign w_a    = {{din1_WIDTH{r_s1_a[din0_WIDTH-1]}}, r_s1_a};
        assign w_b    = {{din0_WIDTH{r_s1_b[din1_WIDTH-1]}}, r_s1_b};
        assign w_prod = w_a * w_b;

        if (NUM_STAGE == 2) begin : g_direct
            assign w_fin_prod  = w_prod;
            assign w_fin_vld   = r_s1_vld;
            assign w_fin_acc   = r_s1_acc;
            assign w_fin_first = r_s1_first;
        end else begin : g_mid
            localparam int c_mid = NUM_STAGE - 2;
            logic signed [c_pw-1:0] r_m_prod [c_mid];
            logic [c_mid-1:0]       r_m_vld;
            logic [c_mid-1:0]       r_m_acc;
            logic [c_mid-1:0]       r_m_first;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < c_mid; i++) r_m_prod[i] <= '0;
                    r_m_vld   <= '0;
                    r_m_acc   <= '0;
                    r_m_first <= '0;
                end else if (ce) begin
                    for (int i = c_mid - 1; i > 0; i--) begin
                        r_m_prod[i]  <= r_m_prod[i-1];
                        r_m_vld[i]   <= r_m_vld[i-1];
                        r_m_acc[i]   <= r_m_acc[i-1];
                        r_m_first[i] <= r_m_first[i-1];
                    end
                    r_m_prod[0]  <= w_prod;
                    r_m_vld[0]   <= r_s1_vld;
                    r_m_acc[0]   <= r_s1_acc;
                    r_m_first[0] <= r_s1_first;
                end
            end

            assign w_fin_prod  = r_m_prod[c_mid-1];
            assign w_fin_vld   = r_m_vld[c_mid-1];
            assign w_fin_acc   = r_m_acc[c_mid-1];
            assign w_fin_first = r_m_first[c_mid-1];
        end
    end

    // ---------------------------------------------------------------- final
    logic [dout_WIDTH-1:0]      r_acc;
    logic [dout_WIDTH-1:0]      r_dout;
    logic                       r_vld;
    logic                       r_ovf;
    logic [c_sw-1:0]            w_prod_ext;
    logic [c_sw-1:0]            w_acc_ext;
    logic [c_sw-1:0]            w_sum;
    logic [c_sw-dout_WIDTH:0]   w_top;
    logic                       w_fits;
    logic [dout_WIDTH-1:0]      w_res;

    assign w_prod_ext = {{(c_sw-c_pw){w_fin_prod[c_pw-1]}}, w_fin_prod};
    assign w_acc_ext  = {{(c_sw-dout_WIDTH){r_acc[dout_WIDTH-1]}}, r_acc};
    assign w_sum      = (w_fin_acc && !w_fin_first) ? (w_acc_ext + w_prod_ext) : w_prod_ext;

    // Value fits when every bit from the dout sign bit upward agrees.
    assign w_top  = w_sum[c_sw-1:dout_WIDTH-1];
    assign w_fits = (&w_top) | ~(|w_top);

    always_comb begin
        w_res = w_sum[dout_WIDTH-1:0];
        if (SATURATE && !w_fits) begin
            w_res = w_sum[c_sw-1] ? c_min : c_max;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc  <= '0;
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ce) begin
            r_vld <= w_fin_vld;
            // Bubbles leave dout/ovf/accumulator holding their last values.
            if (w_fin_vld) begin
                r_dout <= w_res;
                r_ovf  <= ~w_fits;
                if (w_fin_acc) r_acc <= w_res;
            end
        end
    end

    assign dout_vld = r_vld;
    assign dout     = r_dout;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mac_pipe_ce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_myproject_mac_pipe_ce
// Purpose  : Self-checking bench for myproject_mac_pipe_ce. Three instances
//            share one stimulus: 3-stage wrap (main), 3-stage saturating,
//            and 1-stage wrap. A vector table drives the main instance;
//            short hand-written sequences cover saturation, single-stage
//            behaviour and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_mac_pipe_ce;

    logic        clk = 1'b0;
    logic        ap_rst_n;
    logic        ce, din_vld, acc_en, acc_first;
    logic [12:0] din0, din1;

    logic               m_vld, s_vld, o_vld;
    logic signed [25:0] m_dout, s_dout, o_dout;
    logic               m_ovf, s_ovf, o_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    myproject_mac_pipe_ce #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(13), .din1_WIDTH(13),
                            .dout_WIDTH(26), .SATURATE(1'b0)) u_main (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld), .acc_en(acc_en),
        .acc_first(acc_first), .din0(din0), .din1(din1),
        .dout_vld(m_vld), .dout(m_dout), .ovf(m_ovf));

    myproject_mac_pipe_ce #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(13), .din1_WIDTH(13),
                            .dout_WIDTH(26), .SATURATE(1'b1)) u_sat (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld), .acc_en(acc_en),
        .acc_first(acc_first), .din0(din0), .din1(din1),
        .dout_vld(s_vld), .dout(s_dout), .ovf(s_ovf));

    myproject_mac_pipe_ce #(.ID(3), .NUM_STAGE(1), .din0_WIDTH(13), .din1_WIDTH(13),
                            .dout_WIDTH(26), .SATURATE(1'b0)) u_one (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld), .acc_en(acc_en),
        .acc_first(acc_first), .din0(din0), .din1(din1),
        .dout_vld(o_vld), .dout(o_dout), .ovf(o_ovf));

    typedef struct {
        logic        ce, vld, acc, first;
        int          a, b;
        logic        ev;
        int          ed;
        logic        eo;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic c, v, ae, af, input int a, b,
                                input logic ev, input int ed, input logic eo);
        vec_t r;
        r.ce = c; r.vld = v; r.acc = ae; r.first = af; r.a = a; r.b = b;
        r.ev = ev; r.ed = ed; r.eo = eo;
        return r;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic step(input logic c, v, ae, af, input int a, b);
        @(negedge clk);
        ce = c; din_vld = v; acc_en = ae; acc_first = af;
        din0 = 13'(a); din1 = 13'(b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ce = 1'b0; din_vld = 1'b0; acc_en = 1'b0; acc_first = 1'b0;
        din0 = '0; din1 = '0;

        //          ce vld acc fst     a      b   ev        ed  eo
        tbl[0]  = mk(1, 1, 0, 0, -4096, -4096, 0,        0, 0);
        tbl[1]  = mk(1, 0, 0, 0,     0,     0, 0,        0, 0);
        tbl[2]  = mk(1, 1, 0, 0,     1,     1, 1, 16777216, 0);
        tbl[3]  = mk(1, 1, 0, 0,     2,     3, 0, 16777216, 0);
        tbl[4]  = mk(1, 0, 0, 0,     0,     0, 1,        1, 0);
        tbl[5]  = mk(1, 1, 0, 0,    -5,     7, 1,        6, 0);
        tbl[6]  = mk(1, 1, 0, 0,  4095, -4096, 0,        6, 0);
        tbl[7]  = mk(1, 1, 1, 1,   100,   200, 1,      -35, 0);
        tbl[8]  = mk(1, 1, 1, 0,   -50,    10, 1, -16773120, 0);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(0, 1, 1, 1, -1234, 999, 1, -16773120, 0);
        tbl[14] = mk(1, 1, 0, 0,     3,     3, 1,    20000, 0);
        tbl[15] = mk(1, 1, 1, 0,     7,     7, 1,    19500, 0);
        tbl[16] = mk(1, 0, 0, 0,     0,     0, 1,        9, 0);
        tbl[17] = mk(1, 0, 0, 0,     0,     0, 1,    19549, 0);
        tbl[18] = mk(1, 0, 0, 0,     0,     0, 0,    19549, 0);

        // Reset state
        #12;
        chk("rst main vld", m_vld, 0);  chk("rst main dout", m_dout, 0); chk("rst main ovf", m_ovf, 0);
        chk("rst sat vld", s_vld, 0);   chk("rst sat dout", s_dout, 0);  chk("rst sat ovf", s_ovf, 0);
        chk("rst one vld", o_vld, 0);   chk("rst one dout", o_dout, 0);  chk("rst one ovf", o_ovf, 0);
        @(negedge clk);
        ap_rst_n = 1'b1;

        // Table: multiply stream with bubbles, accumulation with ce stall and interleaved multiply
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].ce, tbl[i].vld, tbl[i].acc, tbl[i].first, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d vld", i),  m_vld,  tbl[i].ev);
            chk($sformatf("vec%0d dout", i), m_dout, tbl[i].ed);
            chk($sformatf("vec%0d ovf", i),  m_ovf,  tbl[i].eo);
        end

        // Saturating vs wrapping accumulation of 4095*4095 three times
        step(1, 1, 1, 1, 4095, 4095);
        step(1, 1, 1, 0, 4095, 4095);
        step(1, 1, 1, 0, 4095, 4095);
        chk("sat b1 dout", s_dout, 16769025); chk("sat b1 ovf", s_ovf, 0);
        chk("wrap b1 dout", m_dout, 16769025);
        step(1, 0, 0, 0, 0, 0);
        chk("sat b2 dout", s_dout, 33538050); chk("sat b2 ovf", s_ovf, 0);
        chk("wrap b2 dout", m_dout, 33538050); chk("wrap b2 ovf", m_ovf, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("sat b3 vld", s_vld, 1);
        chk("sat b3 dout", s_dout, 33554431); chk("sat b3 ovf", s_ovf, 1);
        chk("wrap b3 dout", m_dout, -16801789); chk("wrap b3 ovf", m_ovf, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("sat after vld", s_vld, 0); chk("sat after ovf hold", s_ovf, 1);

        // Single-stage instance: same-cycle result, interleaved multiply keeps the sum
        step(1, 1, 0, 0, 12, -12);
        chk("one mul vld", o_vld, 1); chk("one mul dout", o_dout, -144); chk("one mul ovf", o_ovf, 0);
        step(1, 1, 1, 1, 10, 10);
        chk("one accf dout", o_dout, 100);
        step(1, 1, 0, 0, 5, 5);
        chk("one imul dout", o_dout, 25);
        step(1, 1, 1, 0, 2, 3);
        chk("one acc dout", o_dout, 106);
        step(1, 0, 0, 0, 0, 0);
        chk("one bubble vld", o_vld, 0); chk("one bubble dout", o_dout, 106);

        // Asynchronous reset with beats in flight
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 1, 0, 2, 2);
        step(1, 1, 1, 0, 3, 3);
        chk("pre-rst vld", m_vld, 1); chk("pre-rst dout", m_dout, 1);
        #2;
        ap_rst_n = 1'b0;
        #0.5;
        chk("arst vld", m_vld, 0); chk("arst dout", m_dout, 0); chk("arst ovf", m_ovf, 0);
        chk("arst sat dout", s_dout, 0);
        #0.5;
        ap_rst_n = 1'b1;
        step(1, 1, 1, 1, 3, 3);
        chk("post-rst vld0", m_vld, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("post-rst vld1", m_vld, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("post-rst new vld", m_vld, 1); chk("post-rst new dout", m_dout, 9);
        step(1, 0, 0, 0, 0, 0);
        chk("post-rst tail vld", m_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
